// File: rtl/latsnq_bank_wr_ctrl.sv
// Write/preset sequencer that turns single-cycle requests into latsnq E/D/SETN waveforms.
// Optional macro LATSNQ_BANK_ADDR_CHECK_EN: out-of-range writes are acked, skipped and flagged on err.
module latsnq_bank_wr_ctrl #(
  parameter int NLAT      = 8,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int PW_CYC    = 2,
  parameter int HOLD_CYC  = 1,
  parameter int RECOV_CYC = 2,
  localparam int AW = (NLAT > 1) ? $clog2(NLAT) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_req,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             pre_req,
  output logic             pre_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NLAT-1:0]  E,
  output logic [WIDTH-1:0] D,
  output logic             SETN
);

  localparam int MAX_A = (SETUP_CYC > PW_CYC) ? SETUP_CYC : PW_CYC;
  localparam int MAX_B = (HOLD_CYC > RECOV_CYC) ? HOLD_CYC : RECOV_CYC;
  localparam int MAXC  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  // The counter holds "cycles remaining minus one" so zero marks the last cycle of a state.
  localparam logic [CW-1:0] CNT_SETUP = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] CNT_PW    = CW'(PW_CYC - 1);
  localparam logic [CW-1:0] CNT_HOLD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_RECOV = CW'(RECOV_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WSETUP = 3'd1,
    WPULSE = 3'd2,
    WHOLD  = 3'd3,
    PRESET = 3'd4,
    RECOV  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [NLAT-1:0]  e_q, e_d;
  logic             setn_q, setn_d;
  logic             wr_ack_q, wr_ack_d;
  logic             pre_ack_q, pre_ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_s;

`ifdef LATSNQ_BANK_ADDR_CHECK_EN
  localparam logic [AW:0] NLAT_W = (AW+1)'(NLAT);
  logic bad_q, bad_d;
  logic err_q, err_d;
`endif

  // Addresses at or beyond NLAT select no word.
  function automatic logic [NLAT-1:0] word_sel(input logic [AW-1:0] a);
    logic [NLAT-1:0] sel;
    sel = {NLAT{1'b0}};
    for (int i = 0; i < NLAT; i++) begin
      sel[i] = (a == AW'(i));
    end
    return sel;
  endfunction

  // Next-state, counter, capture and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    d_d       = d_q;
    wr_ack_d  = 1'b0;
    pre_ack_d = 1'b0;
    done_d    = 1'b0;
    accept_s  = 1'b0;
`ifdef LATSNQ_BANK_ADDR_CHECK_EN
    bad_d     = 1'b0;
    err_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        accept_s = 1'b1;
      end
      WSETUP: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = WPULSE;
          cnt_d   = CNT_PW;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WPULSE: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = WHOLD;
          cnt_d   = CNT_HOLD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WHOLD: begin
        if (cnt_q == CNT_ZERO) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          accept_s = 1'b1;
`ifdef LATSNQ_BANK_ADDR_CHECK_EN
          err_d    = bad_q;
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PRESET: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = RECOV;
          cnt_d   = CNT_RECOV;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RECOV: begin
        if (cnt_q == CNT_ZERO) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          accept_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // The last cycle of an operation arbitrates too, so a waiting request chains with no gap.
    if (accept_s) begin
      if (pre_req) begin
        state_d   = PRESET;
        cnt_d     = CNT_PW;
        pre_ack_d = 1'b1;
      end else if (wr_req) begin
        wr_ack_d = 1'b1;
`ifdef LATSNQ_BANK_ADDR_CHECK_EN
        if ({1'b0, wr_addr} >= NLAT_W) begin
          state_d = WHOLD;
          cnt_d   = CNT_ZERO;
          bad_d   = 1'b1;
        end else begin
          state_d = WSETUP;
          cnt_d   = CNT_SETUP;
          addr_d  = wr_addr;
          d_d     = wr_data;
        end
`else
        state_d = WSETUP;
        cnt_d   = CNT_SETUP;
        addr_d  = wr_addr;
        d_d     = wr_data;
`endif
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      addr_d = addr_q;
    end

    e_d    = (state_d == WPULSE) ? word_sel(addr_d) : {NLAT{1'b0}};
    setn_d = (state_d != PRESET);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops E and raises SETN immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      addr_q    <= {AW{1'b0}};
      d_q       <= {WIDTH{1'b0}};
      e_q       <= {NLAT{1'b0}};
      setn_q    <= 1'b1;
      wr_ack_q  <= 1'b0;
      pre_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef LATSNQ_BANK_ADDR_CHECK_EN
      bad_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      d_q       <= d_d;
      e_q       <= e_d;
      setn_q    <= setn_d;
      wr_ack_q  <= wr_ack_d;
      pre_ack_q <= pre_ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef LATSNQ_BANK_ADDR_CHECK_EN
      bad_q     <= bad_d;
      err_q     <= err_d;
`endif
    end
  end

  assign wr_ack  = wr_ack_q;
  assign pre_ack = pre_ack_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign E       = e_q;
  assign D       = d_q;
  assign SETN    = setn_q;
`ifdef LATSNQ_BANK_ADDR_CHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule
